// File: rtl/keypad_scan_debounce_if.sv
// Keypad-side signal bundle: row sense lines in, column drive, debounced key code and scan clock out.
interface keypad_scan_debounce_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] code;
    logic       keydown;
    logic       scan_clk;

    modport master (
        input  row,
        output col,
        output code,
        output keydown,
        output scan_clk
    );

    modport slave (
        output row,
        input  col,
        input  code,
        input  keydown,
        input  scan_clk
    );
endinterface

// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad scanner with tick-rate press/release debouncing.
// Also exports the prescaler MSB as a slow scan clock for the LED digit multiplexer.
module keypad_scan_debounce #(
    parameter int DIV_BITS  = 16,
    parameter int DEB_TICKS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    keypad_scan_debounce_if.master kp
);
    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

    localparam logic [3:0] DEB = DEB_TICKS[3:0];

    logic [DIV_BITS-1:0] div_q;
    logic [3:0]          row_meta_q;
    logic [3:0]          row_s_q;
    state_t              state_q;
    logic [1:0]          col_idx_q;
    logic [1:0]          r_idx_q;
    logic [3:0]          cnt_q;
    logic [3:0]          code_q;
    logic                keydown_q;

    logic       tick;
    logic [1:0] low_idx;
    logic [3:0] cnt_inc;
    logic       key_low;

    assign tick    = &div_q;
    assign cnt_inc = cnt_q + 4'd1;
    assign key_low = !row_s_q[r_idx_q];

    // Lowest-index low row wins when several rows share the driven column.
    always_comb begin
        low_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!row_s_q[i]) low_idx = 2'(i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q      <= '0;
            row_meta_q <= 4'hF;
            row_s_q    <= 4'hF;
        end else begin
            div_q      <= div_q + 1'b1;
            row_meta_q <= kp.row;
            row_s_q    <= row_meta_q;
        end
    end

    // Column stays frozen outside SCAN, so col_idx_q doubles as the latched column index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= SCAN;
            col_idx_q <= 2'd0;
            r_idx_q   <= 2'd0;
            cnt_q     <= 4'd0;
            code_q    <= 4'h0;
            keydown_q <= 1'b0;
        end else if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (&row_s_q) begin
                        col_idx_q <= col_idx_q + 2'd1;
                    end else begin
                        r_idx_q <= low_idx;
                        if (DEB == 4'd1) begin
                            code_q    <= {low_idx, col_idx_q};
                            keydown_q <= 1'b1;
                            cnt_q     <= 4'd0;
                            state_q   <= HELD;
                        end else begin
                            cnt_q   <= 4'd1;
                            state_q <= DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (key_low) begin
                        if (cnt_inc == DEB) begin
                            code_q    <= {r_idx_q, col_idx_q};
                            keydown_q <= 1'b1;
                            cnt_q     <= 4'd0;
                            state_q   <= HELD;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end else begin
                        cnt_q   <= 4'd0;
                        state_q <= SCAN;
                    end
                end
                HELD: begin
                    if (!key_low) begin
                        if (cnt_inc == DEB) begin
                            keydown_q <= 1'b0;
                            cnt_q     <= 4'd0;
                            state_q   <= SCAN;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end else begin
                        cnt_q <= 4'd0;
                    end
                end
                default: state_q <= SCAN;
            endcase
        end
    end

    assign kp.col      = ~(4'b0001 << col_idx_q);
    assign kp.code     = code_q;
    assign kp.keydown  = keydown_q;
    assign kp.scan_clk = div_q[DIV_BITS-1];
endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Randomised keypad presses, bounces and release glitches against a tick-level timing model; a monitor checks every keydown edge.
module tb_keypad_scan_debounce;
    localparam int DEB = 4;
    localparam int PER = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    keypad_scan_debounce_if kif ();

    keypad_scan_debounce #(.DIV_BITS(4), .DEB_TICKS(DEB)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kif)
    );

    // Physical keypad: pressed[r][c] shorts row r to column c.
    logic [3:0] pressed [4];
    logic [3:0] row_drv;
    always_comb begin
        row_drv = 4'hF;
        for (int r = 0; r < 4; r++) row_drv[r] = !(|(pressed[r] & ~kif.col));
    end
    assign kif.row = row_drv;

    int cyc;
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic       level;
        logic [3:0] code;
        int         tmin;
        int         tmax;
    } exp_t;
    exp_t exp_q[$];

    logic       mon_en  = 1'b0;
    logic       kd_prev = 1'b0;
    logic [3:0] last_code = 4'h0;

    always @(negedge clk) begin
        if (mon_en && (kif.keydown !== kd_prev)) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_edge: keydown=%0b code=%h tick=%0d, required no edge",
                         kif.keydown, kif.code, cyc / PER);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (kif.keydown !== e.level || kif.code !== e.code ||
                    (cyc / PER) < e.tmin || (cyc / PER) > e.tmax) begin
                    miscompares++;
                    $display("FAIL keydown_edge: got level=%0b code=%h tick=%0d, required level=%0b code=%h tick %0d..%0d",
                             kif.keydown, kif.code, cyc / PER, e.level, e.code, e.tmin, e.tmax);
                end
            end
        end
        kd_prev <= kif.keydown;
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Advance to the middle of the next scan period, well clear of the tick sample.
    task automatic wait_mid();
        do @(negedge clk); while (cyc % PER != 8);
    endtask

    task automatic wait_samples(input int n);
        repeat (n) wait_mid();
    endtask

    task automatic clear_keys();
        for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
    endtask

    task automatic idle_glitch();
        int r, c;
        r = $urandom_range(0, 3);
        c = $urandom_range(0, 3);
        pressed[r][c] = 1'b1;
        wait_samples($urandom_range(1, DEB - 1));
        clear_keys();
        wait_samples(2);
    endtask

    task automatic do_press();
        int r1, r2, rmin, c, s, h, xr, xc;
        logic [3:0] exp_code;
        chk("code_retained", kif.code, last_code);
        c  = $urandom_range(0, 3);
        r1 = $urandom_range(0, 3);
        r2 = r1;
        if ($urandom_range(0, 3) == 0) r2 = (r1 + $urandom_range(1, 3)) % 4;
        rmin = (r1 < r2) ? r1 : r2;
        exp_code = {2'(rmin), 2'(c)};
        pressed[r1][c] = 1'b1;
        pressed[r2][c] = 1'b1;
        s = cyc / PER + 1;
        exp_q.push_back('{1'b1, exp_code, s + DEB - 1, s + DEB - 1 + 3});
        wait_samples(8);
        if ($urandom_range(0, 1) == 1) begin
            xr = $urandom_range(0, 3);
            xc = (c + $urandom_range(1, 3)) % 4;
            pressed[xr][xc] = 1'b1;
        end
        if ($urandom_range(0, 1) == 1) begin
            pressed[r1][c] = 1'b0;
            pressed[r2][c] = 1'b0;
            wait_samples($urandom_range(1, DEB - 1));
            pressed[r1][c] = 1'b1;
            pressed[r2][c] = 1'b1;
            wait_samples($urandom_range(2, 4));
        end
        clear_keys();
        h = cyc / PER + 1;
        exp_q.push_back('{1'b0, exp_code, h + DEB - 1, h + DEB - 1});
        last_code = exp_code;
        wait_samples($urandom_range(DEB + 1, DEB + 4));
    endtask

    initial begin
        int k;
        logic [3:0] exp_col;
        logic [3:0] sc;
        clear_keys();
        repeat (3) @(negedge clk);
        chk("reset_col", kif.col, 4'hE);
        chk("reset_code", kif.code, 4'h0);
        chk("reset_keydown", {3'b0, kif.keydown}, 4'h0);
        chk("reset_scan_clk", {3'b0, kif.scan_clk}, 4'h0);
        rst = 1'b1;

        // Idle scanning: column rotates once per tick, scan_clk is div MSB.
        for (int i = 0; i < 4 * PER + 4; i++) begin
            @(negedge clk);
            k = (cyc / PER) % 4;
            exp_col = ~(4'b0001 << k);
            sc = {3'b0, ((cyc % PER) >= 8)};
            chk("idle_col", kif.col, exp_col);
            chk("idle_scan_clk", {3'b0, kif.scan_clk}, sc);
            chk("idle_keydown", {3'b0, kif.keydown}, 4'h0);
        end

        mon_en = 1'b1;
        wait_mid();
        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 1) == 1) idle_glitch();
            do_press();
        end

        k = 0;
        while (exp_q.size() != 0 && k < 200 * PER) begin
            @(negedge clk);
            k++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: got %0d pending edges, required 0", exp_q.size());
        end

        // Hold row1 on column 3 (code 7), then assert reset while keydown is high.
        wait_mid();
        pressed[1][3] = 1'b1;
        k = cyc / PER + 1;
        exp_q.push_back('{1'b1, 4'h7, k + DEB - 1, k + DEB - 1 + 3});
        k = 0;
        while (kif.keydown !== 1'b1 && k < 12 * PER) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        chk("held_keydown", {3'b0, kif.keydown}, 4'h1);
        chk("held_code", kif.code, 4'h7);
        mon_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("async_keydown", {3'b0, kif.keydown}, 4'h0);
        chk("async_code", kif.code, 4'h0);
        chk("async_col", kif.col, 4'hE);
        chk("async_scan_clk", {3'b0, kif.scan_clk}, 4'h0);
        chk("async_pending", 4'(exp_q.size()), 4'h0);
        clear_keys();
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
